riscv_mem_responder: RTL
========================

# riscv_mem_responder

Unified instruction/data memory target for the multicycle RISC-V core. It accepts one word-aligned read or byte-masked write per request over a valid/ready request channel, then returns data or an error over a valid/ready response channel after a fixed number of wait states. It sits between the core's memory port (instruction fetch and load/store share the port) and a word-addressed RAM array.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; must be a power of two.
- `LATENCY`, 1: wait cycles inserted between accept and response; legal range 0..15, checked at elaboration.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: write data, little-endian lanes.
- `req_wstrb` in 4: byte-lane enables for writes; ignored on reads.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: requester accepts the response.
- `resp_rdata` out 32: read data; 0 for writes and errors.
- `resp_err` out 1: misaligned or out-of-range access.

## Operation
- States:
  - INIT: one cycle after reset; `req_ready`=0. Always goes to IDLE.
  - IDLE: `req_ready`=1. On `req_valid`, capture `we`, `addr`, `wdata` and `wstrb`, and compute `err`. Go to WAIT if `LATENCY`>0, otherwise to RESP.
  - WAIT: 4-bit counter loaded with `LATENCY`-1 on accept and decremented each cycle. Go to RESP when the counter is 0.
  - RESP: `resp_valid`=1. On `resp_ready`, go to IDLE.
- `req_ready` is decoded only from the state register (IDLE) and never depends combinationally on `req_valid`.
- Error conditions:
  - `err` = (`addr[1:0]` != 0) OR (`addr[31:2]` >= `DEPTH`).
  - On error there is no array access, `resp_rdata`=0 and `resp_err`=1.
- Array access happens on the edge that enters RESP, and only when there is no error:
  - Write: each byte lane i with `wstrb[i]`=1 is written from `wdata[8i+7:8i]`. `wstrb`=0 is a legal write that changes nothing.
  - Read: `resp_rdata` is loaded from the word at `addr[31:2]`.
- `resp_rdata` and `resp_err` are registered and held stable for the whole RESP state, including under backpressure.
- Requests presented outside IDLE are not accepted. The requester holds `req_*` stable until the handshake.
- `resp_ready` high before `resp_valid` has no effect.
- Reset (asynchronous, any state):
  - State goes to INIT; `resp_valid`, `resp_err` and `resp_rdata` go to 0; `req_ready` goes to 0.
  - A write still in WAIT is abandoned and never performed.
  - Array contents are not reset.
- Array contents power up undefined. Benches preload them through a hierarchical or `$readmemh` load.

## Timing
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- `req_ready` first rises in the second cycle after `rst_n` deasserts.
- For a request accepted in cycle c (`req_valid` and `req_ready` both high at the rising edge ending c), `resp_valid` is first high in cycle c+1+`LATENCY`.
- When the response handshake completes in cycle r, `req_ready` is 1 in cycle r+1.
- Maximum throughput is one transaction per `LATENCY`+2 cycles.
- Read-after-write to the same word returns the new data because the accesses are strictly serialized.

## Structure
- Shared package `riscv_mem_pkg`:
  - State enum (INIT, IDLE, WAIT, RESP).
  - `WSTRB_ALL` = 4'hF.
  - Function returning the word-index width, $clog2(`DEPTH`).
- Sub-module `riscv_mem_array`:
  - `DEPTH`×32 synchronous RAM with byte-lane write enables and a registered read port.
  - Single port, one access per cycle.
  - The FSM, counter, error check and response registers live in `riscv_mem_responder`.

## Test plan
1. Read after preload, `LATENCY`=1. Preload word 5 = 32'hDEADBEEF and read `addr` 32'h14 → `resp_valid` in cycle c+2 with `resp_rdata`=32'hDEADBEEF and `resp_err`=0.
2. Byte-masked write. Write 32'h11223344 with `wstrb`=4'b0101 to `addr` 32'h20 (word preloaded 0), then read it back → 32'h00220044.
3. Errors, no array access:
   - `addr` 32'h22 → `resp_err`=1, `resp_rdata`=0.
   - `addr` = `DEPTH`×4 → `resp_err`=1.
   - In both cases, an error write leaves the target word unchanged.
4. Backpressure. Hold `resp_ready`=0 for 5 cycles → `resp_valid`, `resp_rdata` and `resp_err` stay stable and `req_ready` stays 0. Release → `req_ready`=1 in the next cycle.
5. Latency sweep. With `LATENCY`=0, `resp_valid` is at c+1. With `LATENCY`=15, `resp_valid` is at c+16. Back-to-back requests achieve exactly `LATENCY`+2 cycles per transaction.
6. Reset mid-write. Assert `rst_n`=0 during WAIT of a write of 32'hCAFEF00D → outputs go to 0 immediately. After reset, reading the word returns its old value, and `req_ready` returns two cycles after release.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the RISC-V unified memory responder.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [3:0] WSTRB_ALL = 4'hF;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/riscv_mem_array.sv
// Word-addressed RAM with byte-lane write enables and a registered read port.
module riscv_mem_array
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IW    = idx_width(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    wstrb,
  input  logic [IW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/riscv_mem_responder.sv
// Valid/ready memory target for the multicycle RISC-V core: one serialized
// read or byte-masked write per request, response after LATENCY wait cycles.
//
// state   | meaning
// INIT    | first cycle out of reset, not yet accepting
// IDLE    | req_ready high, waiting for a request
// WAIT    | counting down LATENCY wait cycles
// RESP    | resp_valid high, holding response until resp_ready
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         IW     = idx_width(DEPTH);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("riscv_mem_responder: LATENCY must be within 0..15");
  end
  if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("riscv_mem_responder: DEPTH must be a power of two");
  end

  state_t      state, state_d;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        resp_err_q, rd_ok_q;

  logic        accept, enter_resp, arr_en;
  logic        sel_we, sel_err;
  logic [31:0] sel_addr, sel_wdata, arr_rdata;
  logic [3:0]  sel_wstrb;

  // With LATENCY=0 the array is accessed on the accept edge, so the live
  // request bus feeds the array directly while in IDLE.
  assign accept    = (state == ST_IDLE) && req_valid;
  assign sel_we    = (state == ST_IDLE) ? req_we    : we_q;
  assign sel_addr  = (state == ST_IDLE) ? req_addr  : addr_q;
  assign sel_wdata = (state == ST_IDLE) ? req_wdata : wdata_q;
  assign sel_wstrb = (state == ST_IDLE) ? req_wstrb : wstrb_q;
  assign sel_err   = (sel_addr[1:0] != 2'b00) ||
                     ({2'b00, sel_addr[31:2]} >= 32'(DEPTH));
  assign arr_en    = enter_resp && !sel_err;

  always_comb begin
    state_d    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    enter_resp = 1'b0;
    case (state)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      resp_err_q <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        cnt     <= LAT_M1;
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        resp_err_q <= sel_err;
        rd_ok_q    <= !sel_we && !sel_err;
      end else if (state == ST_RESP && resp_ready) begin
        resp_err_q <= 1'b0;
        rd_ok_q    <= 1'b0;
      end
    end
  end

  // Read data lives in the array's output register; rd_ok_q forces zero
  // for writes, errors and after reset.
  assign resp_rdata = rd_ok_q ? arr_rdata : 32'd0;
  assign resp_err   = resp_err_q;

  riscv_mem_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (sel_we),
    .wstrb (sel_wstrb),
    .addr  (sel_addr[IW+1:2]),
    .wdata (sel_wdata),
    .rdata (arr_rdata)
  );

endmodule
